bits3_emissor: RTL and testbench
================================

BITS3_EMISSOR -- requirements
Module: bits3_emissor

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of cycles a code is held on the lines; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1: number of all-zero cycles forced after each hold; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to transmit; sampled only in IDLE.
REQ-006 sel  input  1  target interface: 0 = interface A (a,b,c), 1 = interface B (d,e,f).
REQ-007 bits3  input  3  code to transmit; sampled together with start.
REQ-008 a, b, c  output  1 each  interface A lines, registered.
REQ-009 d, e, f  output  1 each  interface B lines, registered.
REQ-010 busy  output  1  high while a transfer (hold or gap) is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of the gap.
REQ-012 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-013 FSM states: IDLE, HOLD, GAP.
REQ-014 IDLE -> HOLD when start=1 and bits3!=000; sel and bits3 are captured into internal registers on that edge.
REQ-015 Bit mapping is reversed. For sel=0: a=bits3[0], b=bits3[1], c=bits3[2]. For sel=1: d=bits3[0], e=bits3[1], f=bits3[2].
REQ-016 The non-selected interface SHALL read 000 in every cycle.
REQ-017 Latency: the lines show the code from the first cycle after the start edge and hold it for exactly HOLD_CYCLES cycles.
REQ-018 HOLD -> GAP after HOLD_CYCLES cycles; all six lines read 0 for exactly GAP_CYCLES cycles.
REQ-019 GAP -> IDLE after GAP_CYCLES cycles; done pulses high in the last GAP cycle.
REQ-020 busy = 1 in HOLD and GAP; busy = 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no queueing and no err.
REQ-022 start in IDLE with bits3=000 SHALL be rejected: the FSM stays in IDLE, err pulses one cycle later, and the lines stay 000.
REQ-023 In the same cycle that done is high, start is not sampled; a new transfer can begin on the first IDLE cycle.
REQ-024 Changes to bits3 and sel after capture SHALL NOT affect the transfer in progress.
REQ-025 At most one of the two interfaces is ever nonzero, and never both in the same cycle.
REQ-026 The hold/gap counter is 8 bits wide and counts down to 1 without wrapping.

Reset
REQ-027 On rst_n=0 the block enters IDLE immediately (asynchronous), and a..f, busy, done and err all read 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer; no done is generated afterwards.
REQ-029 After rst_n deasserts, the first start can be accepted on the first rising edge.

Structure
REQ-030 The state encoding for IDLE/HOLD/GAP and the 3-bit code width constant belong in the shared bits3 package.
REQ-031 The design is a single FSM with one down-counter; the line mapping is a natural sub-module, bits3_mapeador (combinational: sel and code to a..f), whose outputs are registered in bits3_emissor.

Verification
REQ-032 Test 1: reset, then start, sel=1, bits3=100 (default parameters). Required: def=001 for 4 cycles, 000 for 1 cycle, done in the 6th cycle after start, busy high for 5 cycles.
REQ-033 Test 2: start, sel=0, bits3=011. Required: abc=110 for 4 cycles, def=000 throughout.
REQ-034 Test 3: start with bits3=000. Required: err pulse in the next cycle, busy=0, all lines 0.
REQ-035 Test 4: start with sel=0, bits3=101, then a second start with bits3=111 in cycle 2. Required: abc stays 101, the second start is ignored, and exactly one done is seen.
REQ-036 Test 5: rst_n=0 in the 2nd HOLD cycle. Required: lines 000 asynchronously, busy=0, and no done.
REQ-037 Test 6: HOLD_CYCLES=1, GAP_CYCLES=3, back-to-back starts. Required: 1 code cycle, then 3 zero cycles, done, and the next transfer begins on the first IDLE cycle.

Source files
------------

// File: rtl/bits3_emissor_pkg.sv
// Shared definitions for the 3-bit code emitter.
// Contents:
//   CODE_W  - width of the transmitted code
//   CNT_W   - width of the hold/gap down-counter
//   state_e - FSM state encoding (IDLE, HOLD, GAP)
//   lines_t - the six output lines a..f, grouped so they register as one word
package bits3_emissor_pkg;

  localparam int CODE_W = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
  } lines_t;

endpackage

// File: rtl/bits3_emissor_if.sv
// Bus between a requester and the 3-bit code emitter.
// Signals:
//   start, sel, bits3 - transfer request (requester -> emitter)
//   a, b, c           - interface A lines (emitter -> outside)
//   d, e, f           - interface B lines (emitter -> outside)
//   busy, done, err   - transfer status (emitter -> requester)
// Modports: master = requester side, slave = emitter side.
interface bits3_emissor_if;
  import bits3_emissor_pkg::*;

  logic              start;
  logic              sel;
  logic [CODE_W-1:0] bits3;
  logic              a;
  logic              b;
  logic              c;
  logic              d;
  logic              e;
  logic              f;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, sel, bits3,
    input  a, b, c, d, e, f, busy, done, err
  );

  modport slave (
    input  start, sel, bits3,
    output a, b, c, d, e, f, busy, done, err
  );

endinterface

// File: rtl/bits3_emissor_mapeador.sv
// Combinational line mapper: routes a 3-bit code onto interface A or B.
// Ports:
//   sel   - 0 selects interface A (a,b,c), 1 selects interface B (d,e,f)
//   code  - code to place on the selected interface
//   lines - all six lines; the non-selected interface is always 000
// The mapping is bit-reversed with respect to the line names:
// a/d carry code[0], b/e carry code[1], c/f carry code[2].
module bits3_mapeador
  import bits3_emissor_pkg::*;
(
  input  logic              sel,
  input  logic [CODE_W-1:0] code,
  output lines_t            lines
);

  always_comb begin
    lines = '0;
    if (!sel) begin
      lines.a = code[0];
      lines.b = code[1];
      lines.c = code[2];
    end else begin
      lines.d = code[0];
      lines.e = code[1];
      lines.f = code[2];
    end
  end

endmodule

// File: rtl/bits3_emissor.sv
// 3-bit code emitter.
// Accepts a one-cycle start request with a nonzero code, drives that code on
// the selected interface for HOLD_CYCLES cycles, then forces all lines low for
// GAP_CYCLES cycles, pulsing done in the last gap cycle. A start with code 000
// in IDLE is rejected with a one-cycle err pulse.
// Parameters:
//   HOLD_CYCLES - cycles the code is held on the lines (1..255)
//   GAP_CYCLES  - all-zero cycles after each hold (1..255)
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - request/lines/status bundle (slave side)
module bits3_emissor
  import bits3_emissor_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bits3_emissor_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [CODE_W-1:0] code_q, code_d;
  lines_t            lines_q, lines_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              map_sel;
  logic [CODE_W-1:0] map_code;
  lines_t            map_lines;

  // All outputs are registered, so the mapper is fed with what the lines must
  // show in the *next* cycle; a zero code yields all-zero lines.
  bits3_mapeador u_mapeador (
    .sel   (map_sel),
    .code  (map_code),
    .lines (map_lines)
  );

  assign lines_d = map_lines;

  // Next-state logic. The counter holds the number of cycles still to spend in
  // the current state including the present one, so a state is left when the
  // counter reads 1 and the counter never decrements past 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    code_d   = code_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    map_sel  = sel_q;
    map_code = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.bits3 != '0) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_INIT;
            sel_d    = bus.sel;
            code_d   = bus.bits3;
            map_sel  = bus.sel;
            map_code = bus.bits3;
            busy_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        busy_d = 1'b1;
        if (cnt_q == 8'd1) begin
          state_d = ST_GAP;
          cnt_d   = GAP_INIT;
          done_d  = (GAP_INIT == 8'd1);
        end else begin
          cnt_d    = cnt_q - 8'd1;
          map_code = code_q;
        end
      end

      ST_GAP: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - 8'd1;
          busy_d = 1'b1;
          done_d = (cnt_q == 8'd2);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      code_q  <= '0;
      lines_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.a    = lines_q.a;
  assign bus.b    = lines_q.b;
  assign bus.c    = lines_q.c;
  assign bus.d    = lines_q.d;
  assign bus.e    = lines_q.e;
  assign bus.f    = lines_q.f;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bits3_emissor.sv
// Testbench for bits3_emissor: one instance with default timing and one with
// HOLD_CYCLES=1, GAP_CYCLES=3. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_bits3_emissor;

  logic clk;
  logic rst_n;

  int assertions;
  int failures;

  bits3_emissor_if bus ();
  bits3_emissor_if bus6 ();

  bits3_emissor #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bits3_emissor #(.HOLD_CYCLES(1), .GAP_CYCLES(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       start;
    logic       sel;
    logic [2:0] bits3;
    logic [2:0] abc;
    logic [2:0] def;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[22];

  // Packed view {a,b,c,d,e,f,busy,done,err} of each DUT.
  function automatic logic [8:0] busVec();
    return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [8:0] bus6Vec();
    return {bus6.a, bus6.b, bus6.c, bus6.d, bus6.e, bus6.f, bus6.busy, bus6.done, bus6.err};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] required);
    assertions++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: abc_def_busy_done_err got %b required %b", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic sel, input logic [2:0] bits3);
    bus.start = start;
    bus.sel   = sel;
    bus.bits3 = bits3;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus6(input logic start, input logic sel, input logic [2:0] bits3);
    bus6.start = start;
    bus6.sel   = sel;
    bus6.bits3 = bits3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  done_count;
    logic got_done;

    assertions = 0;
    failures   = 0;

    // start, sel, bits3 | abc, def, busy, done, err (after the edge)
    vecs[0]  = '{1'b1, 1'b1, 3'b100, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b100, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b011, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b111, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b101, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b111, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'b111, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'b111, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};

    bus.start  = 1'b0;
    bus.sel    = 1'b0;
    bus.bits3  = 3'b000;
    bus6.start = 1'b0;
    bus6.sel   = 1'b0;
    bus6.bits3 = 3'b000;

    // Reset state.
    rst_n = 1'b0;
    #1;
    checkOutput("reset state", busVec(), 9'b0);
    checkOutput("reset state dut6", bus6Vec(), 9'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tests 1-4: cycle-by-cycle vectors on the default instance.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].start, vecs[i].sel, vecs[i].bits3);
      checkOutput($sformatf("vec%0d", i), busVec(),
                  {vecs[i].abc, vecs[i].def, vecs[i].busy, vecs[i].done, vecs[i].err});
    end

    // Test 5: reset in the second HOLD cycle aborts the transfer.
    applyStimulus(1'b1, 1'b0, 3'b010);
    checkOutput("t5 hold1", busVec(), {3'b010, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("t5 hold2", busVec(), {3'b010, 3'b000, 1'b1, 1'b0, 1'b0});
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 async reset", busVec(), 9'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      if (bus.done || bus.busy) done_count++;
    end
    checkOutput("t5 no done after abort", 9'(done_count), 9'd0);

    // Start accepted on the first rising edge after reset release.
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.sel   = 1'b1;
    bus.bits3 = 3'b001;
    @(posedge clk);
    #1;
    checkOutput("held in reset", busVec(), 9'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first edge start", busVec(), {3'b000, 3'b100, 1'b1, 1'b0, 1'b0});
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      if (bus.done) got_done = 1'b1;
    end
    checkOutput("drain done seen", 9'(got_done), 9'd1);

    // Test 6: HOLD_CYCLES=1, GAP_CYCLES=3, start held high back-to-back.
    applyStimulus6(1'b1, 1'b0, 3'b001);
    checkOutput("t6 code", bus6Vec(), {3'b100, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b1, 1'b0, 3'b001);
    checkOutput("t6 gap1", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b1, 1'b0, 3'b001);
    checkOutput("t6 gap2", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b1, 1'b0, 3'b001);
    checkOutput("t6 gap3 done", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b1, 1'b0});
    applyStimulus6(1'b1, 1'b1, 3'b011);
    checkOutput("t6 first idle", bus6Vec(), 9'b0);
    applyStimulus6(1'b1, 1'b1, 3'b011);
    checkOutput("t6 second code", bus6Vec(), {3'b000, 3'b110, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b0, 1'b0, 3'b000);
    checkOutput("t6 second gap1", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b0, 1'b0, 3'b000);
    checkOutput("t6 second gap2", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
    applyStimulus6(1'b0, 1'b0, 3'b000);
    checkOutput("t6 second done", bus6Vec(), {3'b000, 3'b000, 1'b1, 1'b1, 1'b0});
    applyStimulus6(1'b0, 1'b0, 3'b000);
    checkOutput("t6 back to idle", bus6Vec(), 9'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
